// File: rtl/prev_prime_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prev_prime_pkg
//  Brief    : Shared constants and FSM encoding for the previous-prime finder.
//  Revision : 1.0  initial release
// ============================================================================
package prev_prime_pkg;

  // Datapath width of candidates, divisors and results
  localparam int C_DATA_W        = 32;
  // Default number of parallel trial-division lanes
  localparam int C_LANES_DEFAULT = 8;

  // Search controller states (encoding is visible on the debug port)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_TEST  = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/prime_lane.sv
`default_nettype none
// ============================================================================
//  Module   : prime_lane
//  Brief    : One trial-division lane. Reports whether its divisor is still
//             within sqrt(candidate) and whether it divides the candidate.
//  Revision : 1.0  initial release
// ============================================================================
module prime_lane
  import prev_prime_pkg::*;
(
  input  logic [C_DATA_W-1:0] candidate,
  input  logic [C_DATA_W-1:0] divisor,
  output logic                active,
  output logic                divides
);

  logic [2*C_DATA_W-1:0] w_square;
  logic [C_DATA_W-1:0]   w_rem;
  logic                  w_div_nz;

  // Double-width square keeps the bound check exact for any 32-bit divisor;
  // a zero divisor never claims to divide.
  always_comb begin
    w_square = {{C_DATA_W{1'b0}}, divisor} * {{C_DATA_W{1'b0}}, divisor};
    active   = (w_square <= {{C_DATA_W{1'b0}}, candidate});
    w_div_nz = (divisor != '0);
    w_rem    = w_div_nz ? (candidate % divisor) : candidate;
    divides  = active && w_div_nz && (w_rem == '0);
  end

endmodule
`default_nettype wire

// File: rtl/prev_prime_finder.sv
`default_nettype none
// ============================================================================
//  Module   : prev_prime_finder
//  Brief    : Finds the largest prime strictly below start_val by walking
//             candidates downward and trial-dividing each one with LANES odd
//             divisors per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module prev_prime_finder
  import prev_prime_pkg::*;
#(
  parameter int LANES = C_LANES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [C_DATA_W-1:0] start_val,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [C_DATA_W-1:0] prime_val,
  output logic [C_DATA_W-1:0] count,
  output logic [2:0]          state
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [C_DATA_W-1:0] r_count;
  logic [C_DATA_W-1:0] w_count_nxt;
  logic [C_DATA_W-1:0] r_div;
  logic [C_DATA_W-1:0] w_div_nxt;
  logic                r_found;
  logic                w_found_nxt;
  logic [C_DATA_W-1:0] r_prime;
  logic [C_DATA_W-1:0] w_prime_nxt;

  logic [C_DATA_W-1:0] w_lane_div [LANES];
  logic [LANES-1:0]    w_active;
  logic [LANES-1:0]    w_divides;
  logic                w_any_div;
  logic                w_all_active;

  // Lane k tests odd divisor d + 2k against the current candidate
  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lanes
      assign w_lane_div[k] = r_div + C_DATA_W'(2 * k);
      prime_lane u_lane (
        .candidate (r_count),
        .divisor   (w_lane_div[k]),
        .active    (w_active[k]),
        .divides   (w_divides[k])
      );
    end
  endgenerate

  // Reduce lane results: any factor found, or every lane still in range
  always_comb begin
    w_any_div    = |w_divides;
    w_all_active = &w_active;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath update decisions
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_div_nxt   = r_div;
    w_found_nxt = r_found;
    w_prime_nxt = r_prime;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_found_nxt = 1'b0;
          w_prime_nxt = '0;
          if (start_val <= C_DATA_W'(2)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_count_nxt = start_val - C_DATA_W'(1);
            w_state_nxt = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (r_count < C_DATA_W'(2)) begin
          w_found_nxt = 1'b0;
          w_state_nxt = ST_DONE;
        end else if (r_count == C_DATA_W'(2) || r_count == C_DATA_W'(3)) begin
          w_found_nxt = 1'b1;
          w_prime_nxt = r_count;
          w_state_nxt = ST_DONE;
        end else if (!r_count[0]) begin
          // Even candidates above 2 are skipped without a division pass
          w_count_nxt = r_count - C_DATA_W'(1);
        end else begin
          w_div_nxt   = C_DATA_W'(3);
          w_state_nxt = ST_TEST;
        end
      end
      ST_TEST: begin
        if (w_any_div) begin
          // Composite odd candidate (>= 9), next odd one is two below
          w_count_nxt = r_count - C_DATA_W'(2);
          w_state_nxt = ST_CHECK;
        end else if (w_all_active) begin
          w_div_nxt   = r_div + C_DATA_W'(2 * LANES);
        end else begin
          w_found_nxt = 1'b1;
          w_prime_nxt = r_count;
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Candidate, divisor base and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_div   <= '0;
      r_found <= 1'b0;
      r_prime <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_div   <= w_div_nxt;
      r_found <= w_found_nxt;
      r_prime <= w_prime_nxt;
    end
  end

  // Output decode
  always_comb begin
    busy      = (r_state == ST_CHECK) || (r_state == ST_TEST);
    done      = (r_state == ST_DONE);
    found     = r_found;
    prime_val = r_prime;
    count     = r_count;
    state     = r_state;
  end

endmodule
`default_nettype wire

// File: tb/tb_prev_prime_finder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prev_prime_finder
//  Brief    : Self-checking bench for prev_prime_finder: directed scenarios
//             plus random origins checked against a plain trial-division model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prev_prime_finder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] start_val;
  logic        busy;
  logic        done;
  logic        found;
  logic [31:0] prime_val;
  logic [31:0] count;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  prev_prime_finder #(.LANES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_val (start_val),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .prime_val (prime_val),
    .count     (count),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic bit is_prime(input longint unsigned n);
    if (n < 2) return 1'b0;
    for (longint unsigned i = 2; i * i <= n; i++)
      if (n % i == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Largest prime strictly below v, 0 when none exists
  function automatic longint unsigned ref_prev(input longint unsigned v);
    for (longint unsigned n = v; n > 2; n--)
      if (is_prime(n - 1)) return n - 1;
    return 0;
  endfunction

  // Present start at a falling edge; returns just after the sampling edge
  task automatic issue(input logic [31:0] val);
    @(negedge clk);
    start     = 1'b1;
    start_val = val;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count edges until done is seen, bounded
  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    while (!done && edges < budget) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!done) check("timeout", 64'(done), 64'd1);
  endtask

  initial begin
    int edges;
    logic [31:0] v;

    rst_n     = 1'b0;
    start     = 1'b0;
    start_val = '0;
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_outs", {busy, done, found}, 3'b000);
    check("rst_prime", 64'(prime_val), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First start after reset is honoured; 1000 -> 997 via 999 (multiple of 3)
    issue(32'd1000);
    check("k1000_cnt0", 64'(count), 64'd999);
    check("k1000_busy", 64'(busy), 64'd1);
    step(2);
    check("k1000_cnt1", 64'(count), 64'd997);
    wait_done(200, edges);
    check("k1000_found", 64'(found), 64'd1);
    check("k1000_prime", 64'(prime_val), 64'd997);

    // Restart from DONE: done drops on the start edge; 1163 needs two full
    // divisor passes (3..17, 19..33) then a pass with no lane in range
    issue(32'd1164);
    check("k1164_done_drop", 64'(done), 64'd0);
    check("k1164_prime_clr", 64'(prime_val), 64'd0);
    wait_done(200, edges);
    check("k1164_lat", 64'(edges), 64'd4);
    check("k1164_prime", 64'(prime_val), 64'd1163);
    check("k1164_found", 64'(found), 64'd1);

    // 10: CHECK 9, TEST (9%3), CHECK 7, TEST -> DONE; done is high after the
    // fourth edge following the sampling edge (fifth edge counting it)
    issue(32'd10);
    step(3);
    check("k10_not_yet", 64'(done), 64'd0);
    step(1);
    check("k10_done", 64'(done), 64'd1);
    check("k10_prime", 64'(prime_val), 64'd7);

    issue(32'd3);
    wait_done(20, edges);
    check("k3_found", 64'(found), 64'd1);
    check("k3_prime", 64'(prime_val), 64'd2);

    for (int i = 0; i <= 2; i++) begin
      issue(32'(i));
      check("small_done", 64'(done), 64'd1);
      check("small_found", 64'(found), 64'd0);
      check("small_prime", 64'(prime_val), 64'd0);
    end

    // Asynchronous abort mid-search
    issue(32'd1164);
    step(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_state", 64'(state), 64'd0);
    check("abort_outs", {busy, done, found}, 3'b000);
    check("abort_prime", 64'(prime_val), 64'd0);
    check("abort_count", 64'(count), 64'd0);
    #2;
    rst_n = 1'b1;
    issue(32'd1000);
    wait_done(200, edges);
    check("post_abort_prime", 64'(prime_val), 64'd997);

    // Start while busy is ignored
    issue(32'd1000);
    @(negedge clk);
    start     = 1'b1;
    start_val = 32'd50;
    step(1);
    start = 1'b0;
    wait_done(200, edges);
    check("busy_ign_prime", 64'(prime_val), 64'd997);

    // Random origins against the reference model
    for (int r = 0; r < 14; r++) begin
      v = (r < 4) ? 32'($urandom_range(0, 40)) : 32'($urandom_range(41, 60000));
      issue(v);
      wait_done(5000, edges);
      check("rand_found", 64'(found), 64'(ref_prev(64'(v)) != 0));
      check("rand_prime", 64'(prime_val), ref_prev(64'(v)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
